// File: rtl/multi_channel_pid_controller.sv
// -----------------------------------------------------------------------------
// multi_channel_pid_controller
//
// Time-multiplexed PID controller. One rising edge on update_controller sweeps
// channels 0..NUM_CHANNELS-1 through a shared LOAD/MUL/SUM/WRITE pipeline, four
// cycles per channel. Each visit computes
//   err  = sp - position (mode 00) or sp - velocity (mode 01)
//   sum  = (Kp*err + Kd*(err-lastError) + Ki*integral_next) >>> outputShift
//   duty = clamp(sum, outputNegMax, outputPosMax)   (upper clamp applied last)
// Mode 10 drives duty = sp directly, mode 11 drives duty = 0. Both clear the
// channel's integrator and lastError.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   update_controller     sweep request, rising-edge triggered
//   control_mode  [2N]    per-channel mode (00 pos, 01 vel, 10 direct, 11 off)
//   Kp, Ki, Kd    [N*DW]  per-channel signed gains
//   sp            [N*DW]  per-channel signed setpoint
//   position      [N*DW]  per-channel signed position feedback
//   velocity      [N*DW]  per-channel signed velocity feedback
//   outputPosMax/outputNegMax  shared signed duty clamp
//   deadBand      [DW]    shared non-negative error deadband
//   integralMax   [DW]    shared non-negative integrator magnitude limit
//   outputShift   [6]     arithmetic right shift of the PID sum
//   duty          [N*DW]  per-channel signed duty, registered
//   busy / done / overrun sweep in progress / sweep-complete pulse / sticky
//                         "edge arrived while busy"
// -----------------------------------------------------------------------------
module multi_channel_pid_controller #(
    parameter int NUM_CHANNELS = 6,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               update_controller,
    input  logic [2*NUM_CHANNELS-1:0]          control_mode,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Kp,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Ki,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] Kd,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] sp,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] position,
    input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] velocity,
    input  logic [DATA_WIDTH-1:0]              outputPosMax,
    input  logic [DATA_WIDTH-1:0]              outputNegMax,
    input  logic [DATA_WIDTH-1:0]              deadBand,
    input  logic [DATA_WIDTH-1:0]              integralMax,
    input  logic [5:0]                         outputShift,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] duty,
    output logic                               busy,
    output logic                               done,
    output logic                               overrun
);

    localparam int CH_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int DW   = DATA_WIDTH;
    localparam int MW   = 2 * DATA_WIDTH;       // Kp/Ki product width
    localparam int DMW  = 2 * DATA_WIDTH + 1;   // Kd product width (derr is DW+1)
    localparam int PW   = 2 * DATA_WIDTH + 2;   // sum width, cannot overflow
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CHANNELS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_MUL   = 3'd2,
        S_SUM   = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    // Saturate a DW+1 bit difference into DW bits so a huge setpoint/feedback
    // gap pins the error instead of flipping its sign.
    function automatic logic signed [DW-1:0] sat_err(input logic signed [DW:0] d);
        logic signed [DW:0]   hi;
        logic signed [DW:0]   lo;
        logic signed [DW-1:0] res;
        hi = {2'b00, {(DW-1){1'b1}}};
        lo = {2'b11, {(DW-1){1'b0}}};
        if (d > hi) begin
            res = hi[DW-1:0];
        end else if (d < lo) begin
            res = lo[DW-1:0];
        end else begin
            res = d[DW-1:0];
        end
        return res;
    endfunction

    // Clamp the DW+1 bit integrator sum to +/-lim; the result always fits DW.
    function automatic logic signed [DW-1:0] clamp_int(input logic signed [DW:0] s,
                                                       input logic [DW-1:0]     lim);
        logic signed [DW:0]   hi;
        logic signed [DW:0]   lo;
        logic signed [DW-1:0] res;
        hi = {1'b0, lim};
        lo = -hi;
        if (s > hi) begin
            res = hi[DW-1:0];
        end else if (s < lo) begin
            res = lo[DW-1:0];
        end else begin
            res = s[DW-1:0];
        end
        return res;
    endfunction

    // Unpacked per-channel views of the flat input buses.
    logic signed [DW-1:0] w_kp_a  [NUM_CHANNELS];
    logic signed [DW-1:0] w_ki_a  [NUM_CHANNELS];
    logic signed [DW-1:0] w_kd_a  [NUM_CHANNELS];
    logic signed [DW-1:0] w_sp_a  [NUM_CHANNELS];
    logic signed [DW-1:0] w_pos_a [NUM_CHANNELS];
    logic signed [DW-1:0] w_vel_a [NUM_CHANNELS];
    logic [1:0]           w_mode_a[NUM_CHANNELS];

    // Per-channel persistent state.
    logic signed [DW-1:0] r_last_err [NUM_CHANNELS];
    logic signed [DW-1:0] r_integral [NUM_CHANNELS];
    logic [1:0]           r_mode_prev[NUM_CHANNELS];
    logic signed [DW-1:0] r_duty_a   [NUM_CHANNELS];

    // Control.
    state_t          r_state;
    state_t          w_state_next;
    logic [CH_W-1:0] r_ch;
    logic            r_update_prev;
    logic            w_edge;
    logic            r_busy;
    logic            r_done;
    logic            r_overrun;

    // LOAD-stage combinational results.
    logic [1:0]           w_mode;
    logic                 w_mode_chg;
    logic signed [DW-1:0] w_last_eff;
    logic signed [DW-1:0] w_int_eff;
    logic signed [DW-1:0] w_fb;
    logic signed [DW-1:0] w_err;
    logic signed [DW:0]   w_derr;
    logic signed [DW:0]   w_int_sum;
    logic signed [DW-1:0] w_int_next;
    logic signed [DW:0]   w_err_ext;
    logic signed [DW:0]   w_db_ext;
    logic                 w_in_db;

    // Pipeline registers captured in LOAD.
    logic [1:0]           r_mode;
    logic                 r_in_db;
    logic signed [DW-1:0] r_err;
    logic signed [DW:0]   r_derr;
    logic signed [DW-1:0] r_int_next;
    logic signed [DW-1:0] r_sp;
    logic signed [DW-1:0] r_kp;
    logic signed [DW-1:0] r_ki;
    logic signed [DW-1:0] r_kd;
    logic [5:0]           r_shift;
    logic signed [DW-1:0] r_pos_max;
    logic signed [DW-1:0] r_neg_max;

    // MUL/SUM-stage registers and WRITE-stage combinational results.
    logic signed [MW-1:0]  r_prod_p;
    logic signed [DMW-1:0] r_prod_d;
    logic signed [MW-1:0]  r_prod_i;
    logic signed [PW-1:0]  r_sum_sh;
    logic signed [PW-1:0]  w_sum;
    logic signed [PW-1:0]  w_lo;
    logic signed [PW-1:0]  w_hi;
    logic signed [PW-1:0]  w_lo_applied;
    logic signed [PW-1:0]  w_sat;
    logic signed [DW-1:0]  w_duty_val;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        assign w_kp_a[g]   = Kp[g*DW +: DW];
        assign w_ki_a[g]   = Ki[g*DW +: DW];
        assign w_kd_a[g]   = Kd[g*DW +: DW];
        assign w_sp_a[g]   = sp[g*DW +: DW];
        assign w_pos_a[g]  = position[g*DW +: DW];
        assign w_vel_a[g]  = velocity[g*DW +: DW];
        assign w_mode_a[g] = control_mode[g*2 +: 2];
        assign duty[g*DW +: DW] = r_duty_a[g];
    end

    assign w_edge  = update_controller & ~r_update_prev;
    assign busy    = r_busy;
    assign done    = r_done;
    assign overrun = r_overrun;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: four cycles per channel, back to IDLE after the last.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_edge) begin
                    w_state_next = S_LOAD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_LOAD:  w_state_next = S_MUL;
            S_MUL:   w_state_next = S_SUM;
            S_SUM:   w_state_next = S_WRITE;
            S_WRITE: begin
                if (r_ch == LAST_CH) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_LOAD;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // LOAD-stage math for the selected channel: error, derivative, integrator.
    always_comb begin
        w_mode     = w_mode_a[r_ch];
        w_mode_chg = (w_mode != r_mode_prev[r_ch]);
        // A mode switch restarts the history so the derivative does not kick.
        if (w_mode_chg) begin
            w_last_eff = '0;
            w_int_eff  = '0;
        end else begin
            w_last_eff = r_last_err[r_ch];
            w_int_eff  = r_integral[r_ch];
        end
        if (w_mode == 2'b01) begin
            w_fb = w_vel_a[r_ch];
        end else begin
            w_fb = w_pos_a[r_ch];
        end
        w_err     = sat_err({w_sp_a[r_ch][DW-1], w_sp_a[r_ch]} - {w_fb[DW-1], w_fb});
        w_err_ext = {w_err[DW-1], w_err};
        w_derr    = w_err_ext - {w_last_eff[DW-1], w_last_eff};
        w_int_sum = {w_int_eff[DW-1], w_int_eff} + w_err_ext;
        w_db_ext  = {1'b0, deadBand};
        w_in_db   = (w_err_ext < w_db_ext) && (w_err_ext > -w_db_ext);
        // Inside the deadband the integrator holds its value.
        if (w_in_db) begin
            w_int_next = w_int_eff;
        end else begin
            w_int_next = clamp_int(w_int_sum, integralMax);
        end
    end

    // SUM/WRITE-stage math: widen, add, then clamp with the upper bound last.
    always_comb begin
        w_sum = PW'(r_prod_p) + PW'(r_prod_d) + PW'(r_prod_i);
        w_lo  = PW'(r_neg_max);
        w_hi  = PW'(r_pos_max);
        if (r_sum_sh < w_lo) begin
            w_lo_applied = w_lo;
        end else begin
            w_lo_applied = r_sum_sh;
        end
        if (w_lo_applied > w_hi) begin
            w_sat = w_hi;
        end else begin
            w_sat = w_lo_applied;
        end
        case (r_mode)
            2'b10:   w_duty_val = r_sp;
            2'b11:   w_duty_val = '0;
            default: begin
                if (r_in_db) begin
                    w_duty_val = '0;
                end else begin
                    w_duty_val = w_sat[DW-1:0];
                end
            end
        endcase
    end

    // Datapath, per-channel state, status flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_update_prev <= 1'b0;
            r_ch          <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_overrun     <= 1'b0;
            r_mode        <= 2'b00;
            r_in_db       <= 1'b0;
            r_err         <= '0;
            r_derr        <= '0;
            r_int_next    <= '0;
            r_sp          <= '0;
            r_kp          <= '0;
            r_ki          <= '0;
            r_kd          <= '0;
            r_shift       <= 6'd0;
            r_pos_max     <= '0;
            r_neg_max     <= '0;
            r_prod_p      <= '0;
            r_prod_d      <= '0;
            r_prod_i      <= '0;
            r_sum_sh      <= '0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_last_err[i]  <= '0;
                r_integral[i]  <= '0;
                r_mode_prev[i] <= 2'b00;
                r_duty_a[i]    <= '0;
            end
        end else begin
            r_update_prev <= update_controller;
            r_done        <= 1'b0;
            if (w_edge && (r_state != S_IDLE)) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_edge) begin
                        r_ch   <= '0;
                        r_busy <= 1'b1;
                    end
                end
                S_LOAD: begin
                    r_mode     <= w_mode;
                    r_in_db    <= w_in_db;
                    r_err      <= w_err;
                    r_derr     <= w_derr;
                    r_int_next <= w_int_next;
                    r_sp       <= w_sp_a[r_ch];
                    r_kp       <= w_kp_a[r_ch];
                    r_ki       <= w_ki_a[r_ch];
                    r_kd       <= w_kd_a[r_ch];
                    r_shift    <= outputShift;
                    r_pos_max  <= outputPosMax;
                    r_neg_max  <= outputNegMax;
                end
                S_MUL: begin
                    r_prod_p <= MW'(r_kp) * MW'(r_err);
                    r_prod_d <= DMW'(r_kd) * DMW'(r_derr);
                    r_prod_i <= MW'(r_ki) * MW'(r_int_next);
                end
                S_SUM: begin
                    r_sum_sh <= w_sum >>> r_shift;
                    // done is registered one cycle early so it is high
                    // during the final WRITE cycle.
                    if (r_ch == LAST_CH) begin
                        r_done <= 1'b1;
                    end
                end
                S_WRITE: begin
                    r_duty_a[r_ch]    <= w_duty_val;
                    r_mode_prev[r_ch] <= r_mode;
                    if (r_mode[1]) begin
                        r_last_err[r_ch] <= '0;
                        r_integral[r_ch] <= '0;
                    end else begin
                        r_last_err[r_ch] <= r_err;
                        r_integral[r_ch] <= r_int_next;
                    end
                    if (r_ch == LAST_CH) begin
                        r_busy <= 1'b0;
                    end else begin
                        r_ch <= r_ch + 1'b1;
                    end
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multi_channel_pid_controller.sv
module tb_multi_channel_pid_controller;

    localparam int N  = 6;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              update_controller = 1'b0;
    logic [2*N-1:0]    control_mode;
    logic [N*DW-1:0]   Kp, Ki, Kd, sp, position, velocity;
    logic [DW-1:0]     outputPosMax, outputNegMax, deadBand, integralMax;
    logic [5:0]        outputShift;
    wire  [N*DW-1:0]   duty;
    wire               busy, done, overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    multi_channel_pid_controller #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset), .update_controller(update_controller),
        .control_mode(control_mode), .Kp(Kp), .Ki(Ki), .Kd(Kd), .sp(sp),
        .position(position), .velocity(velocity),
        .outputPosMax(outputPosMax), .outputNegMax(outputNegMax),
        .deadBand(deadBand), .integralMax(integralMax), .outputShift(outputShift),
        .duty(duty), .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    function automatic int dget(input int ch);
        logic [DW-1:0] v;
        v = duty[ch*DW +: DW];
        return $signed(v);
    endfunction

    task automatic set_ch(input int ch, input logic [1:0] m, input int kp, input int ki,
                          input int kd, input int spv, input int posv, input int velv);
        control_mode[ch*2 +: 2] = m;
        Kp[ch*DW +: DW]       = kp;
        Ki[ch*DW +: DW]       = ki;
        Kd[ch*DW +: DW]       = kd;
        sp[ch*DW +: DW]       = spv;
        position[ch*DW +: DW] = posv;
        velocity[ch*DW +: DW] = velv;
    endtask

    // Reset for 3 cycles, all channels disabled, shared limits at defaults.
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        control_mode = {N{2'b11}};
        Kp = '0; Ki = '0; Kd = '0; sp = '0; position = '0; velocity = '0;
        outputPosMax = 32'sd500;
        outputNegMax = -32'sd500;
        deadBand     = 32'd0;
        integralMax  = 32'd0;
        outputShift  = 6'd0;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // One sweep; n counts cycles after the edge cycle k. Optional extra pulse
    // at cycle k+pulse_at. Bounded to 4N+4 cycles.
    task automatic run_sweep(input int pulse_at, input int watch,
                             output int done_at, output int done_cnt, output int first_chg);
        int init_v;
        @(negedge clock);
        init_v = dget(watch);
        update_controller = 1'b1;
        done_at = -1; done_cnt = 0; first_chg = -1;
        for (int n = 1; n <= 4*N + 4; n++) begin
            @(negedge clock);
            if (n == 1 || n == pulse_at + 1) update_controller = 1'b0;
            if (n == pulse_at) update_controller = 1'b1;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = n;
            end
            if (first_chg < 0 && dget(watch) != init_v) first_chg = n;
        end
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        n_cmp++; if (duty !== '0) begin n_fail++; $display("FAIL reset_duty: got %h expected 0", duty); end
        n_cmp++; if ({busy, done, overrun} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {busy, done, overrun}); end
    endtask

    task automatic test_pos_p();
        int da, dc, fc;
        do_reset();
        set_ch(2, 2'b00, 4, 0, 0, 1000, 900, 0);
        outputShift = 6'd2;
        run_sweep(0, 2, da, dc, fc);
        n_cmp++; if (dget(2) !== 100) begin n_fail++; $display("FAIL p_duty2: got %0d expected 100", dget(2)); end
        n_cmp++; if (fc !== 13) begin n_fail++; $display("FAIL p_duty2_cycle: got %0d expected 13", fc); end
        n_cmp++; if (da !== 24) begin n_fail++; $display("FAIL p_done_cycle: got %0d expected 24", da); end
        n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL p_done_count: got %0d expected 1", dc); end
        n_cmp++; if (dget(0) !== 0 || dget(5) !== 0) begin n_fail++; $display("FAIL p_disabled: got %0d/%0d expected 0/0", dget(0), dget(5)); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL p_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_windup();
        int da, dc, fc;
        int exp_d[5] = '{1000, 2000, 2000, 2000, 2000};
        do_reset();
        set_ch(3, 2'b00, 0, 1, 0, 1000, 0, 0);
        integralMax  = 32'd2500;
        outputPosMax = 32'sd2000;
        outputNegMax = -32'sd2000;
        for (int s = 0; s < 5; s++) begin
            run_sweep(0, 3, da, dc, fc);
            n_cmp++; if (dget(3) !== exp_d[s]) begin n_fail++; $display("FAIL windup_sweep%0d: got %0d expected %0d", s, dget(3), exp_d[s]); end
        end
        // err=0 with a loose clamp exposes the pinned integrator directly.
        outputPosMax = 32'sd10000;
        sp[3*DW +: DW] = 1000; position[3*DW +: DW] = 1000;
        run_sweep(0, 3, da, dc, fc);
        n_cmp++; if (dget(3) !== 2500) begin n_fail++; $display("FAIL windup_pinned: got %0d expected 2500", dget(3)); end
        sp[3*DW +: DW] = 0;
        run_sweep(0, 3, da, dc, fc);
        n_cmp++; if (dget(3) !== 1500) begin n_fail++; $display("FAIL windup_unwind: got %0d expected 1500", dget(3)); end
        // Inverted limits: the upper clamp wins.
        outputPosMax = -32'sd100;
        outputNegMax = 32'sd100;
        run_sweep(0, 3, da, dc, fc);
        n_cmp++; if (dget(3) !== -100) begin n_fail++; $display("FAIL inverted_limits: got %0d expected -100", dget(3)); end
    endtask

    task automatic test_deadband();
        int da, dc, fc;
        int sps[5]   = '{5, 25, -10, 9, 10};
        int exp_d[5] = '{0, 40, -70, 0, 2};
        do_reset();
        set_ch(4, 2'b00, 0, 0, 2, 0, 0, 0);
        deadBand = 32'd10;
        for (int s = 0; s < 5; s++) begin
            sp[4*DW +: DW] = sps[s];
            run_sweep(0, 4, da, dc, fc);
            n_cmp++; if (dget(4) !== exp_d[s]) begin n_fail++; $display("FAIL deadband_sp%0d: got %0d expected %0d", sps[s], dget(4), exp_d[s]); end
        end
    endtask

    task automatic test_modes();
        int da, dc, fc;
        do_reset();
        set_ch(0, 2'b10, 0, 0, 0, -123, 0, 0);
        set_ch(1, 2'b11, 1, 0, 0, 50, 0, 0);
        set_ch(5, 2'b00, 0, 0, 3, 100, 0, 0);
        run_sweep(0, 0, da, dc, fc);
        n_cmp++; if (dget(0) !== -123) begin n_fail++; $display("FAIL direct: got %0d expected -123", dget(0)); end
        n_cmp++; if (dget(1) !== 0) begin n_fail++; $display("FAIL disabled: got %0d expected 0", dget(1)); end
        n_cmp++; if (dget(5) !== 300) begin n_fail++; $display("FAIL ch5_deriv: got %0d expected 300", dget(5)); end
        sp[0*DW +: DW] = -1000;
        set_ch(1, 2'b00, 0, 0, 3, 7, 0, 0);
        set_ch(5, 2'b01, 0, 0, 3, 7, 555, 0);
        run_sweep(0, 0, da, dc, fc);
        n_cmp++; if (dget(0) !== -1000) begin n_fail++; $display("FAIL direct_unclamped: got %0d expected -1000", dget(0)); end
        n_cmp++; if (dget(1) !== 21) begin n_fail++; $display("FAIL enable_deriv: got %0d expected 21", dget(1)); end
        n_cmp++; if (dget(5) !== 21) begin n_fail++; $display("FAIL modechange_clear: got %0d expected 21", dget(5)); end
    endtask

    task automatic test_overrun();
        int da, dc, fc;
        do_reset();
        set_ch(2, 2'b00, 4, 0, 0, 1000, 900, 0);
        outputShift = 6'd2;
        @(negedge clock);
        n_cmp++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_before: got %b expected 0", overrun); end
        run_sweep(5, 2, da, dc, fc);
        n_cmp++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b expected 1", overrun); end
        n_cmp++; if (dc !== 1 || da !== 24) begin n_fail++; $display("FAIL ovr_done: got count %0d at %0d expected 1 at 24", dc, da); end
        n_cmp++; if (dget(2) !== 100) begin n_fail++; $display("FAIL ovr_duty: got %0d expected 100", dget(2)); end
        run_sweep(0, 2, da, dc, fc);
        n_cmp++; if (overrun !== 1'b1 || dc !== 1) begin n_fail++; $display("FAIL ovr_sticky: got ovr %b count %0d expected 1 1", overrun, dc); end
    endtask

    task automatic test_reset_mid_sweep();
        int da, dc, fc;
        do_reset();
        set_ch(2, 2'b00, 4, 0, 0, 1000, 900, 0);
        set_ch(3, 2'b00, 0, 1, 0, 1000, 0, 0);
        outputShift  = 6'd2;
        outputPosMax = 32'sd5000;
        outputNegMax = -32'sd5000;
        integralMax  = 32'd2500;
        run_sweep(0, 3, da, dc, fc);
        n_cmp++; if (dget(3) !== 250) begin n_fail++; $display("FAIL mid_pre_ch3: got %0d expected 250", dget(3)); end
        // Second sweep, overrun pulse at k+5, reset at k+15 (ch2 written, ch3 not).
        @(negedge clock);
        update_controller = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            @(negedge clock);
            if (n == 1 || n == 6) update_controller = 1'b0;
            if (n == 5) update_controller = 1'b1;
        end
        n_cmp++; if (busy !== 1'b1 || overrun !== 1'b1) begin n_fail++; $display("FAIL mid_pre_flags: got busy %b ovr %b expected 1 1", busy, overrun); end
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        n_cmp++; if (duty !== '0) begin n_fail++; $display("FAIL mid_duty: got %h expected 0", duty); end
        n_cmp++; if ({busy, done, overrun} !== 3'b000) begin n_fail++; $display("FAIL mid_flags: got %b expected 000", {busy, done, overrun}); end
        run_sweep(0, 3, da, dc, fc);
        n_cmp++; if (dget(3) !== 250 || dget(2) !== 100) begin n_fail++; $display("FAIL mid_after: got %0d/%0d expected 250/100", dget(3), dget(2)); end
        n_cmp++; if (da !== 24 || overrun !== 1'b0) begin n_fail++; $display("FAIL mid_after_done: got at %0d ovr %b expected 24 0", da, overrun); end
    endtask

    initial begin
        test_reset();
        test_pos_p();
        test_windup();
        test_deadband();
        test_modes();
        test_overrun();
        test_reset_mid_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
